// File: rtl/la_iopwrseq.sv
`default_nettype none
// ============================================================================
// Module      : la_iopwrseq
// Description : IO-ring power sequencer. Qualifies the analog supply-good
//               indication, then enables ring segments in a fixed staged
//               order and disables them in reverse. Supply loss while any
//               segment is powered forces every segment off and raises a
//               sticky fault that clears only when the power request drops.
// Revision    : 1.0 - initial release
// ============================================================================
module la_iopwrseq #(
   parameter int NSTAGE   = 4,   // number of sequenced ring segments (1..8)
   parameter int RINGW    = 8,   // ioring bus width, >= NSTAGE+1
   parameter int CNTW     = 16,  // stage delay counter width
   parameter int DEBOUNCE = 16   // consecutive vgood-high cycles before ramp
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              en,
   input  logic              vgood,
   input  logic [CNTW-1:0]   delay,
   output logic [NSTAGE-1:0] stage_en,
   output logic [RINGW-1:0]  ioring,
   output logic              ready,
   output logic              fault,
   output logic              busy
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_IDXW = (NSTAGE > 1)   ? $clog2(NSTAGE)   : 1;
   localparam int c_DBW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   localparam logic [c_IDXW-1:0] c_IDX_LAST = c_IDXW'(NSTAGE - 1);
   localparam logic [c_DBW-1:0]  c_DB_LAST  = c_DBW'(DEBOUNCE - 1);
   localparam logic [NSTAGE-1:0] c_STAGE0   = NSTAGE'(1);

   localparam logic [2:0] c_ST_OFF   = 3'd0;
   localparam logic [2:0] c_ST_DEB   = 3'd1;
   localparam logic [2:0] c_ST_RAMP  = 3'd2;
   localparam logic [2:0] c_ST_ON    = 3'd3;
   localparam logic [2:0] c_ST_DOWN  = 3'd4;
   localparam logic [2:0] c_ST_FAULT = 3'd5;

   // ------------------------------------------------------------------------
   // Registers and next-state wires
   // ------------------------------------------------------------------------
   logic              r_vg_m;
   logic              r_vg_s;
   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;

   logic [NSTAGE-1:0] r_stage_en;
   logic [NSTAGE-1:0] w_stage_en_nxt;
   logic              r_ready;
   logic              w_ready_nxt;
   logic              r_fault;
   logic              w_fault_nxt;
   logic              r_busy;
   logic              w_busy_nxt;

   logic [c_DBW-1:0]  r_dbcnt;
   logic [c_DBW-1:0]  w_dbcnt_nxt;
   logic [CNTW-1:0]   r_timer;
   logic [CNTW-1:0]   w_timer_nxt;
   logic [c_IDXW-1:0] r_idx;
   logic [c_IDXW-1:0] w_idx_nxt;

   logic              w_timer_zero;
   logic              w_down_empty;
   logic [NSTAGE-1:0] w_stage_dn;
   logic [NSTAGE-1:0] w_stage_up;
   logic [RINGW-1:0]  w_ioring;

   // Segments are always enabled from bit 0 upward, so stage_en is a
   // thermometer code: shifting right drops the highest enabled segment and
   // shifting left with a 1 fill enables the next one.
   assign w_stage_dn   = r_stage_en >> 1;
   assign w_stage_up   = (r_stage_en << 1) | c_STAGE0;
   assign w_down_empty = (w_stage_dn == '0);
   assign w_timer_zero = (r_timer == '0);

   // Two-flop synchronizer for the asynchronous supply-good pin
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_vg_m <= 1'b0;
         r_vg_s <= 1'b0;
      end else begin
         r_vg_m <= vgood;
         r_vg_s <= r_vg_m;
      end
   end

   // State register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= c_ST_OFF;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; supply loss takes priority over a dropped request
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_OFF: begin
            if (en && r_vg_s) w_state_nxt = c_ST_DEB;
         end
         c_ST_DEB: begin
            if (!en)
               w_state_nxt = c_ST_OFF;
            else if (r_vg_s && (r_dbcnt == c_DB_LAST))
               w_state_nxt = c_ST_RAMP;
         end
         c_ST_RAMP: begin
            if (!r_vg_s)
               w_state_nxt = c_ST_FAULT;
            else if (!en)
               w_state_nxt = w_down_empty ? c_ST_OFF : c_ST_DOWN;
            else if (w_timer_zero && (r_idx == c_IDX_LAST))
               w_state_nxt = c_ST_ON;
         end
         c_ST_ON: begin
            if (!r_vg_s)
               w_state_nxt = c_ST_FAULT;
            else if (!en)
               w_state_nxt = w_down_empty ? c_ST_OFF : c_ST_DOWN;
         end
         c_ST_DOWN: begin
            if (!r_vg_s)
               w_state_nxt = c_ST_FAULT;
            else if (w_timer_zero && w_down_empty)
               w_state_nxt = c_ST_OFF;
         end
         c_ST_FAULT: begin
            if (!en) w_state_nxt = c_ST_OFF;
         end
         default: w_state_nxt = c_ST_OFF;
      endcase
   end

   // Output and counter next values, registered below
   always_comb begin
      w_stage_en_nxt = r_stage_en;
      w_ready_nxt    = r_ready;
      w_fault_nxt    = r_fault;
      w_busy_nxt     = r_busy;
      w_dbcnt_nxt    = r_dbcnt;
      w_timer_nxt    = r_timer;
      w_idx_nxt      = r_idx;
      case (r_state)
         c_ST_OFF: begin
            w_stage_en_nxt = '0;
            w_ready_nxt    = 1'b0;
            w_fault_nxt    = 1'b0;
            w_busy_nxt     = 1'b0;
            if (en && r_vg_s) w_dbcnt_nxt = '0;
         end
         c_ST_DEB: begin
            if (en) begin
               if (!r_vg_s) begin
                  // any low cycle restarts the qualification window
                  w_dbcnt_nxt = '0;
               end else if (r_dbcnt == c_DB_LAST) begin
                  w_stage_en_nxt = c_STAGE0;
                  w_idx_nxt      = '0;
                  w_timer_nxt    = delay;
                  w_busy_nxt     = 1'b1;
               end else begin
                  w_dbcnt_nxt = r_dbcnt + 1'b1;
               end
            end
         end
         c_ST_RAMP: begin
            if (!r_vg_s) begin
               w_stage_en_nxt = '0;
               w_ready_nxt    = 1'b0;
               w_busy_nxt     = 1'b0;
               w_fault_nxt    = 1'b1;
            end else if (!en) begin
               w_stage_en_nxt = w_stage_dn;
               w_ready_nxt    = 1'b0;
               w_timer_nxt    = delay;
               w_busy_nxt     = !w_down_empty;
            end else if (w_timer_zero) begin
               if (r_idx != c_IDX_LAST) begin
                  w_idx_nxt      = r_idx + 1'b1;
                  w_stage_en_nxt = w_stage_up;
                  w_timer_nxt    = delay;
               end else begin
                  w_ready_nxt = 1'b1;
                  w_busy_nxt  = 1'b0;
               end
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         c_ST_ON: begin
            if (!r_vg_s) begin
               w_stage_en_nxt = '0;
               w_ready_nxt    = 1'b0;
               w_busy_nxt     = 1'b0;
               w_fault_nxt    = 1'b1;
            end else if (!en) begin
               w_stage_en_nxt = w_stage_dn;
               w_ready_nxt    = 1'b0;
               w_timer_nxt    = delay;
               w_busy_nxt     = !w_down_empty;
            end
         end
         c_ST_DOWN: begin
            if (!r_vg_s) begin
               w_stage_en_nxt = '0;
               w_ready_nxt    = 1'b0;
               w_busy_nxt     = 1'b0;
               w_fault_nxt    = 1'b1;
            end else if (w_timer_zero) begin
               w_stage_en_nxt = w_stage_dn;
               w_timer_nxt    = delay;
               w_busy_nxt     = !w_down_empty;
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         c_ST_FAULT: begin
            w_stage_en_nxt = '0;
            w_ready_nxt    = 1'b0;
            w_busy_nxt     = 1'b0;
            w_fault_nxt    = en;
         end
         default: begin
            w_stage_en_nxt = '0;
            w_ready_nxt    = 1'b0;
            w_fault_nxt    = 1'b0;
            w_busy_nxt     = 1'b0;
         end
      endcase
   end

   // Registered outputs and sequencing counters
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_stage_en <= '0;
         r_ready    <= 1'b0;
         r_fault    <= 1'b0;
         r_busy     <= 1'b0;
         r_dbcnt    <= '0;
         r_timer    <= '0;
         r_idx      <= '0;
      end else begin
         r_stage_en <= w_stage_en_nxt;
         r_ready    <= w_ready_nxt;
         r_fault    <= w_fault_nxt;
         r_busy     <= w_busy_nxt;
         r_dbcnt    <= w_dbcnt_nxt;
         r_timer    <= w_timer_nxt;
         r_idx      <= w_idx_nxt;
      end
   end

   // Ring bus: segment enables in the low bits, ready in the top bit
   always_comb begin
      w_ioring                = '0;
      w_ioring[NSTAGE-1:0]    = r_stage_en;
      w_ioring[RINGW-1]       = r_ready;
   end

   assign stage_en = r_stage_en;
   assign ioring   = w_ioring;
   assign ready    = r_ready;
   assign fault    = r_fault;
   assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_la_iopwrseq.sv
`default_nettype none
// ============================================================================
// Module      : tb_la_iopwrseq
// Description : Directed self-checking bench for la_iopwrseq. Every expected
//               output transition (value and cycle) is queued when stimulus
//               is applied; a monitor pops and compares on each change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_la_iopwrseq;

   localparam int NSTAGE   = 4;
   localparam int RINGW    = 8;
   localparam int CNTW     = 16;
   localparam int DEBOUNCE = 16;
   localparam int SW       = RINGW + NSTAGE + 3;

   logic              clk = 1'b0;
   logic              nreset;
   logic              en;
   logic              vgood;
   logic [CNTW-1:0]   delay;
   logic [NSTAGE-1:0] stage_en;
   logic [RINGW-1:0]  ioring;
   logic              ready;
   logic              fault;
   logic              busy;

   la_iopwrseq #(
      .NSTAGE   (NSTAGE),
      .RINGW    (RINGW),
      .CNTW     (CNTW),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .clk      (clk),
      .nreset   (nreset),
      .en       (en),
      .vgood    (vgood),
      .delay    (delay),
      .stage_en (stage_en),
      .ioring   (ioring),
      .ready    (ready),
      .fault    (fault),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          total = 0;
   int          bad   = 0;
   string       phase = "init";
   int          exp_cyc[$];
   logic [SW-1:0] exp_val[$];
   logic        mon_en = 1'b0;
   logic [SW-1:0] prev;
   logic [SW-1:0] snap;

   assign snap = {ioring, stage_en, ready, fault, busy};

   // Expected snapshot built from the ring mapping: low bits = enables, MSB = ready
   function automatic logic [SW-1:0] mk(input logic [NSTAGE-1:0] se, input logic rd,
                                        input logic ft, input logic bs);
      logic [RINGW-1:0] ring;
      ring = '0;
      ring[NSTAGE-1:0] = se;
      ring[RINGW-1] = rd;
      return {ring, se, rd, ft, bs};
   endfunction

   task automatic push(input int at, input logic [SW-1:0] v);
      exp_cyc.push_back(at);
      exp_val.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_val.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      assert (exp_val.size() == 0) else begin
         bad++;
         $error("FAIL %s/timeout pending=%0d expected=0", phase, exp_val.size());
         exp_val.delete();
         exp_cyc.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   // Scoreboard monitor: every output change must match the next queued event
   always @(negedge clk) begin
      if (mon_en && (snap !== prev)) begin
         total++;
         assert (exp_val.size() != 0) else begin
            bad++;
            $error("FAIL %s/unexpected observed=%h expected=no_change", phase, snap);
         end
         if (exp_val.size() != 0) begin
            check("value", 32'(snap), 32'(exp_val.pop_front()));
            check("cycle", 32'(cyc), 32'(exp_cyc.pop_front()));
         end
         prev = snap;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      nreset = 1'b0;
      en     = 1'b0;
      vgood  = 1'b0;
      delay  = 16'd3;
      repeat (3) @(negedge clk);

      phase = "reset";
      check("stage_en", 32'(stage_en), 32'd0);
      check("ioring",   32'(ioring),   32'd0);
      check("ready",    32'(ready),    32'd0);
      check("fault",    32'(fault),    32'd0);
      check("busy",     32'(busy),     32'd0);
      nreset = 1'b1;
      @(negedge clk);
      prev   = snap;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal ramp: 2 sync + 1 OFF + 16 debounce cycles, then 4-cycle stages
      phase = "ramp";
      base  = cyc;
      en    = 1'b1;
      vgood = 1'b1;
      push(base + 19, mk(4'b0001, 1'b0, 1'b0, 1'b1));
      push(base + 23, mk(4'b0011, 1'b0, 1'b0, 1'b1));
      push(base + 27, mk(4'b0111, 1'b0, 1'b0, 1'b1));
      push(base + 31, mk(4'b1111, 1'b0, 1'b0, 1'b1));
      push(base + 35, mk(4'b1111, 1'b1, 1'b0, 1'b0));
      drain(60);
      check("ioring_on", 32'(ioring), 32'h8F);

      // Ramp-down from ON: first clear immediate, then every 4 cycles
      phase = "down";
      base  = cyc;
      en    = 1'b0;
      push(base + 1,  mk(4'b0111, 1'b0, 1'b0, 1'b1));
      push(base + 5,  mk(4'b0011, 1'b0, 1'b0, 1'b1));
      push(base + 9,  mk(4'b0001, 1'b0, 1'b0, 1'b1));
      push(base + 13, mk(4'b0000, 1'b0, 1'b0, 1'b0));
      drain(40);
      check("busy_off", 32'(busy), 32'd0);

      // Debounce glitch at count 10 restarts the window: ramp 11 cycles late
      phase = "glitch";
      base  = cyc;
      en    = 1'b1;
      push(base + 28, mk(4'b0001, 1'b0, 1'b0, 1'b1));
      push(base + 32, mk(4'b0011, 1'b0, 1'b0, 1'b1));
      push(base + 36, mk(4'b0111, 1'b0, 1'b0, 1'b1));
      push(base + 40, mk(4'b1111, 1'b0, 1'b0, 1'b1));
      push(base + 44, mk(4'b1111, 1'b1, 1'b0, 1'b0));
      wait_cyc(base + 9);
      vgood = 1'b0;
      @(negedge clk);
      vgood = 1'b1;
      drain(80);

      // Supply loss while ON: fault after sync latency, sticky until en drops
      phase = "loss";
      base  = cyc;
      vgood = 1'b0;
      push(base + 3, mk(4'b0000, 1'b0, 1'b1, 1'b0));
      drain(20);
      vgood = 1'b1;
      repeat (10) @(negedge clk);
      check("fault_sticky", 32'(fault), 32'd1);
      base = cyc;
      en   = 1'b0;
      push(base + 1, mk(4'b0000, 1'b0, 1'b0, 1'b0));
      drain(20);
      check("fault_clear", 32'(fault), 32'd0);

      // Abort mid-ramp at 0011: 0001 immediately, 0000 four cycles later
      phase = "abort";
      base  = cyc;
      en    = 1'b1;
      push(base + 17, mk(4'b0001, 1'b0, 1'b0, 1'b1));
      push(base + 21, mk(4'b0011, 1'b0, 1'b0, 1'b1));
      push(base + 23, mk(4'b0001, 1'b0, 1'b0, 1'b1));
      push(base + 27, mk(4'b0000, 1'b0, 1'b0, 1'b0));
      wait_cyc(base + 22);
      en = 1'b0;
      drain(60);
      check("ready_abort", 32'(ready), 32'd0);

      // Async reset mid-ramp, then full restart with delay=0
      phase = "areset";
      base  = cyc;
      en    = 1'b1;
      push(base + 17, mk(4'b0001, 1'b0, 1'b0, 1'b1));
      push(base + 20, mk(4'b0000, 1'b0, 1'b0, 1'b0));
      wait_cyc(base + 19);
      #2 nreset = 1'b0;
      #1;
      check("async_stage", 32'(stage_en), 32'd0);
      check("async_busy",  32'(busy),     32'd0);
      check("async_ring",  32'(ioring),   32'd0);
      @(negedge clk);
      repeat (2) @(negedge clk);
      delay  = 16'd0;
      nreset = 1'b1;
      base   = cyc;
      push(base + 19, mk(4'b0001, 1'b0, 1'b0, 1'b1));
      push(base + 20, mk(4'b0011, 1'b0, 1'b0, 1'b1));
      push(base + 21, mk(4'b0111, 1'b0, 1'b0, 1'b1));
      push(base + 22, mk(4'b1111, 1'b0, 1'b0, 1'b1));
      push(base + 23, mk(4'b1111, 1'b1, 1'b0, 1'b0));
      drain(60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/la_iopwrseq.md
Name: la_iopwrseq

Overview:
- IO-ring power sequencer for the gf180 lambda IO library.
- Qualifies the analog supply-good indication from the vdda/vssa supply pads.
- Then enables ring segments in a fixed staged order, and disables them in reverse.
- Sits beside the supply cells in the padring and drives control bits onto the generic ioring bus.

Parameters:
- NSTAGE, 4, number of sequenced ring segments (1..8).
- RINGW, 8, width of ioring bus; must be >= NSTAGE+1.
- CNTW, 16, width of the stage delay counter.
- DEBOUNCE, 16, consecutive cycles vgood must stay high before ramp starts (>=1).

Ports:
- clk  input  1  sequencer clock.
- nreset  input  1  asynchronous active-low reset.
- en  input  1  power-up request; level-sensitive.
- vgood  input  1  asynchronous supply-good from the analog supply sense.
- delay  input  CNTW  per-stage hold time, in cycles minus one.
- stage_en  output  NSTAGE  segment enables; bit k is segment k.
- ioring  output  RINGW  ring control bus.
- ready  output  1  all segments enabled.
- fault  output  1  sticky supply-loss flag.
- busy  output  1  ramp or ramp-down in progress.

Behaviour:
- Reset (nreset low, async):
  - state OFF; all outputs 0; counters 0; synchronizer flops 0.
- vgood synchronizer:
  - Two-flop synchronizer produces vg_s.
  - All uses of vgood below mean vg_s, which lags the pin by 2 cycles.
- ioring mapping:
  - ioring[NSTAGE-1:0] = stage_en.
  - ioring[RINGW-1] = ready.
  - Remaining bits 0.
  - All outputs are registered.
- OFF:
  - en & vg_s -> DEBOUNCE; debounce counter cleared.
- DEBOUNCE:
  - Counter increments while vg_s=1; vg_s=0 clears it and state stays.
  - en=0 -> OFF.
  - When DEBOUNCE consecutive high cycles are counted -> RAMP.
  - On RAMP entry: stage_en[0]=1, idx=0, timer loaded with delay.
- RAMP:
  - Timer decrements each cycle; each stage is held delay+1 cycles.
  - Timer=0 and idx<NSTAGE-1: idx+1, set stage_en[idx+1], reload timer from the current delay input.
  - Timer=0 and idx=NSTAGE-1 -> ON; ready=1 on the next cycle.
  - busy=1.
- ON:
  - ready=1, busy=0.
  - en=0 -> DOWN.
- DOWN:
  - Entered from RAMP (en drop) or ON. ready cleared on entry.
  - Clears the highest set stage_en bit immediately, then one more bit each delay+1 cycles, in reverse order.
  - When stage_en=0 -> OFF. busy=1.
  - en re-asserted during DOWN is ignored until OFF is reached.
- FAULT entry:
  - vg_s=0 in RAMP, ON or DOWN -> FAULT.
  - In the next cycle: stage_en=0, ready=0, busy=0, fault=1.
- FAULT exit:
  - Remain in FAULT while en=1, regardless of vg_s.
  - en=0 -> OFF and fault cleared.
- Simultaneous events:
  - Fault beats en drop.
  - en drop in the same cycle as the final RAMP step goes to DOWN, not ON.
- delay=0 gives a 1-cycle stage spacing.
- NSTAGE=1: RAMP lasts delay+1 cycles, then ON.
- Reset mid-operation clears everything immediately and asynchronously, including sticky fault.

Test Plan:
- Nominal ramp:
  - Stimulus: NSTAGE=4, DEBOUNCE=16, delay=3; vgood=1, en=1.
  - Response: stage_en goes 0001, 0011, 0111, 1111, spaced 4 cycles apart; ready=1 after the last stage completes; ioring=8'h8F.
- Debounce glitch:
  - Stimulus: vgood low for 1 cycle at debounce count 10.
  - Response: counter restarts; RAMP entry is delayed by 11+ cycles; stage_en stays 0 until then.
- Ramp-down:
  - Stimulus: from ON, en=0 with delay=3.
  - Response: 1111 -> 0111 -> 0011 -> 0001 -> 0000, with 4-cycle spacing after the first clear; state OFF; busy=0.
- Supply loss:
  - Stimulus: vgood=0 while ON.
  - Response: within 3 cycles stage_en=0 and fault=1. fault holds while en=1 even if vgood returns; en=0 clears fault.
- Abort mid-ramp:
  - Stimulus: en=0 when stage_en=0011.
  - Response: 0001, then 0000; ready never asserts.
- Async reset:
  - Stimulus: assert nreset low during RAMP, mid-clock.
  - Response: all outputs 0 without waiting for a clock edge; after release with en=1, the full debounce sequence restarts.
